// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, ALU functions, condition
// codes, status codes and the execute-stage FSM states.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // rrmovq / cmovXX
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  // ALU function codes (match the OPq ifun encoding)
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  // Condition codes for jXX / cmovXX
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  // Status codes
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } exec_state_e;

  // Evaluate a branch/cmov condition against a CC snapshot.
  // Out-of-range codes evaluate false.
  function automatic logic cond_eval(input logic [3:0] ifun,
                                     input logic zf, input logic sf,
                                     input logic of);
    logic lt;
    lt = sf ^ of;
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu64.sv
// Combinational ALU computing b op a with Y86 flag generation.
module alu64
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_fn_e      fn,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of
);

  // Result and signed overflow for the selected function.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    result = '0;
    of     = 1'b0;
    case (fn)
      ALU_ADD: begin
        result = b + a;
        of     = (a[W-1] == b[W-1]) && (result[W-1] != b[W-1]);
      end
      ALU_SUB: begin
        result = b - a;
        of     = (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]);
      end
      ALU_AND: result = b & a;
      ALU_XOR: result = b ^ a;
      default: result = '0;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[W-1];

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, condition evaluation,
// condition-code register, sticky halt FSM and the E->M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         d_valid,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [W-1:0] d_valC,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  input  logic [2:0]   d_stat,
  input  logic         stall,
  input  logic         bubble,
  input  logic         set_cc_en,
  output logic         e_valid,
  output logic [3:0]   e_icode,
  output logic         e_cnd,
  output logic [W-1:0] e_valE,
  output logic [W-1:0] e_valA,
  output logic [3:0]   e_dstE,
  output logic [3:0]   e_dstM,
  output logic [2:0]   e_stat,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         halted
);

  exec_state_e state_q, state_d;

  logic         zf_q, sf_q, of_q;
  logic         e_valid_q, e_valid_d;
  logic [3:0]   e_icode_q, e_icode_d;
  logic         e_cnd_q, e_cnd_d;
  logic [W-1:0] e_valE_q, e_valE_d;
  logic [W-1:0] e_valA_q, e_valA_d;
  logic [3:0]   e_dstE_q, e_dstE_d;
  logic [3:0]   e_dstM_q, e_dstM_d;
  logic [2:0]   e_stat_q, e_stat_d;

  logic [W-1:0] alu_a, alu_b, alu_res;
  alu_fn_e      alu_fn;
  logic         alu_zf, alu_sf, alu_of;

  logic         illegal, is_cond, cnd, advance, load, cc_we;
  logic [2:0]   ex_stat;

  assign illegal = ((d_icode == I_OPQ) && (d_ifun > 4'd3)) ||
                   (((d_icode == I_RRMOVQ) || (d_icode == I_JXX)) && (d_ifun > 4'd6));
  assign is_cond = (d_icode == I_RRMOVQ) || (d_icode == I_JXX);
  // Condition uses the CC value before this instruction's own update.
  assign cnd     = is_cond && !illegal && cond_eval(d_ifun, zf_q, sf_q, of_q);
  assign ex_stat = illegal ? STAT_INS : d_stat;

  assign advance = !stall && (state_q == ST_RUN);
  assign load    = advance && !bubble && d_valid;
  assign cc_we   = load && (d_icode == I_OPQ) && (ex_stat == STAT_AOK) && set_cc_en;

  // Route operands so that every valE is computed as b op a.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_fn = ALU_ADD;
    case (d_icode)
      I_RRMOVQ: alu_a = d_valA;
      I_IRMOVQ: alu_a = d_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = d_valC;
        alu_b = d_valB;
      end
      I_OPQ: begin
        alu_a  = d_valA;
        alu_b  = d_valB;
        alu_fn = alu_fn_e'(d_ifun[1:0]);
      end
      I_CALL, I_PUSHQ: begin
        alu_a  = W'(8);
        alu_b  = d_valB;
        alu_fn = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = W'(8);
        alu_b = d_valB;
      end
      default: ;
    endcase
  end

  alu64 #(.W(W)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .fn     (alu_fn),
    .result (alu_res),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  // Next E->M contents: the decoded instruction when loading, else a bubble.
  always_comb begin
    e_valid_d = 1'b0;
    e_icode_d = I_NOP;
    e_cnd_d   = 1'b0;
    e_valE_d  = '0;
    e_valA_d  = '0;
    e_dstE_d  = REG_NONE;
    e_dstM_d  = REG_NONE;
    e_stat_d  = STAT_AOK;
    if (load) begin
      e_valid_d = 1'b1;
      e_icode_d = d_icode;
      e_cnd_d   = cnd;
      e_valE_d  = illegal ? '0 : alu_res;
      e_valA_d  = d_valA;
      e_dstE_d  = (illegal || ((d_icode == I_RRMOVQ) && !cnd)) ? REG_NONE : d_dstE;
      e_dstM_d  = illegal ? REG_NONE : d_dstM;
      e_stat_d  = ex_stat;
    end
  end

  // E->M register: reset to bubble, hold on stall or halt, else advance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      e_valid_q <= 1'b0;
      e_icode_q <= I_NOP;
      e_cnd_q   <= 1'b0;
      e_valE_q  <= '0;
      e_valA_q  <= '0;
      e_dstE_q  <= REG_NONE;
      e_dstM_q  <= REG_NONE;
      e_stat_q  <= STAT_AOK;
    end else if (advance) begin
      e_valid_q <= e_valid_d;
      e_icode_q <= e_icode_d;
      e_cnd_q   <= e_cnd_d;
      e_valE_q  <= e_valE_d;
      e_valA_q  <= e_valA_d;
      e_dstE_q  <= e_dstE_d;
      e_dstM_q  <= e_dstM_d;
      e_stat_q  <= e_stat_d;
    end
  end

  // Condition-code register, written only by a legal AOK OPq load.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_we) begin
      zf_q <= alu_zf;
      sf_q <= alu_sf;
      of_q <= alu_of;
    end
  end

  // Halt FSM next state: loading any non-AOK instruction halts for good.
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_RUN) && load && (ex_stat != STAT_AOK)) state_d = ST_HALTED;
  end

  // Halt FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  assign e_valid = e_valid_q;
  assign e_icode = e_icode_q;
  assign e_cnd   = e_cnd_q;
  assign e_valE  = e_valE_q;
  assign e_valA  = e_valA_q;
  assign e_dstE  = e_dstE_q;
  assign e_dstM  = e_dstM_q;
  assign e_stat  = e_stat_q;
  assign zf      = zf_q;
  assign sf      = sf_q;
  assign of      = of_q;
  assign halted  = (state_q == ST_HALTED);

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the Y86-64 processor, sitting directly downstream of decode/register-read. Each cycle it accepts one decoded instruction (icode, ifun, valA, valB, valC, destinations, status) and computes valE through a 64-bit ALU. It evaluates the branch/cmov condition against the condition-code register, updates CC for OPq, and registers the result into the E→M pipeline register. A sticky halt state blocks all further architectural effects after the first non-AOK instruction.

## Interface
Parameters:
- W, 64, datapath width (valA/valB/valC/valE).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_valid  in  1  decode presents an instruction this cycle.
- d_icode  in  4  instruction code (0 halt … B popq).
- d_ifun  in  4  function / condition code.
- d_valA, d_valB, d_valC  in  W  operands from decode/fetch.
- d_dstE, d_dstM  in  4  destination register IDs (0xF = none).
- d_stat  in  3  status from fetch (AOK=1, HLT=2, ADR=3, INS=4).
- stall  in  1  hold the E→M register and CC unchanged.
- bubble  in  1  load a nop bubble instead of d_*.
- set_cc_en  in  1  downstream permits CC update (0 when M/W hold an exception).
- e_valid  out  1  E→M register holds a real instruction.
- e_icode  out  4  registered icode.
- e_cnd  out  1  registered condition result.
- e_valE, e_valA  out  W  registered ALU result / pass-through valA.
- e_dstE, e_dstM  out  4  registered destinations (dstE forced to 0xF on a not-taken cmov).
- e_stat  out  3  registered status.
- zf, sf, of  out  1  current CC register.
- halted  out  1  sticky halt state.

## Operation
- ALU (valE): cmovXX → valA; irmovq → valC; rmmovq/mrmovq → valB+valC; OPq → valB op valA (0 add, 1 sub = valB−valA, 2 and, 3 xor); call/pushq → valB−8; ret/popq → valB+8; halt/nop/jXX → 0. All arithmetic is mod 2^64.
- Flags (OPq only): ZF = (valE==0); SF = valE[63]. OF for add = (A[63]==B[63]) & (valE[63]!=B[63]). OF for sub = (A[63]!=B[63]) & (valE[63]!=B[63]). OF = 0 for and/xor.
- Cnd, from the CC register value before this instruction's update: 0 always; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=~ZF; 5 ge=~(SF^OF); 6 g=~(SF^OF)&~ZF. Cnd is 0 for icodes other than cmov/jXX.
- Illegal ifun: OPq with ifun>3, or cmov/jXX with ifun>6, sets stat to INS. For such an instruction valE=0, no CC update, dstE=dstM=0xF.
- CC written only on load of an OPq with stat AOK, set_cc_en=1, state RUN.
- FSM:
  - RUN → HALTED when an instruction with stat≠AOK is loaded (the instruction itself is registered with its stat).
  - HALTED: d_* are ignored; the E→M register holds its last value; CC is frozen.
  - Only rst leaves HALTED.
- Priority each edge: rst > stall > HALTED hold > bubble > (d_valid ? load : bubble).
- A bubble register value is valid=0, icode=1, cnd=0, valE=valA=0, dstE=dstM=0xF, stat=AOK.

## Timing
- Latency 1: d_* sampled at edge N appear on e_* after edge N. CC changes take effect on the same edge.
- An OPq loaded at edge N affects e_cnd for an instruction loaded at edge N+1 (back-to-back forwarding through CC needs no stall).
- Reset values: e_* = bubble value, ZF=1, SF=0, OF=0, halted=0.
- stall with bubble: stall wins; outputs and CC held.
- rst asserted mid-HALTED or mid-stall clears to reset values on that edge.

## Structure
- Shared package y86_pkg holds icode constants, ALU fn codes, condition codes, stat codes, and REG_NONE=4'hF; the fetch and decode blocks use the same package.
- One sub-module, alu64: combinational; inputs a, b, fn; outputs result, zf, sf, of.
- execute_stage holds the CC register, the cond logic, the FSM, and the E→M register.

## Test plan
- After reset, OPq add valB=0x7FFF_FFFF_FFFF_FFFF, valA=1 → valE=0x8000_0000_0000_0000, then SF=1, OF=1, ZF=0.
- OPq sub valB=5, valA=5, then jXX ifun=3 (je) next cycle → e_valE=0, ZF=1, second instruction e_cnd=1.
- Prior CC ZF=0, SF=1, OF=0; cmovXX ifun=5 (ge), dstE=3 → e_cnd=0, e_dstE=0xF, valE=valA.
- OPq with set_cc_en=0 → valE correct; zf/sf/of unchanged from reset (1,0,0).
- stall held 2 cycles, bubble also asserted → e_* and CC unchanged. Bubble alone → e_valid=0, e_icode=1.
- Instruction with d_stat=HLT, then OPq xor 0xFF^0xFF → halted=1, e_stat=2 held, ZF unchanged; rst → halted=0, e_* at bubble.
